// File: rtl/rtc_bank_writer_pkg.sv
// Shared types and constants for the RTC bank writer: FSM encodings,
// entry-group bounds and the bank-index to RTC-address map.
package rtc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CYCLE,
    S_DONE
  } wr_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ADDR_LOW,
    PH_ADDR_GAP,
    PH_DATA_LOW,
    PH_DATA_GAP
  } phase_e;

  localparam logic [3:0] BANK_IDLE_ADDR = 4'h9;

  localparam logic [3:0] GRP_ALL_FIRST   = 4'd0;
  localparam logic [3:0] GRP_ALL_LAST    = 4'd8;
  localparam logic [3:0] GRP_TIME_FIRST  = 4'd0;
  localparam logic [3:0] GRP_TIME_LAST   = 4'd2;
  localparam logic [3:0] GRP_DATE_FIRST  = 4'd3;
  localparam logic [3:0] GRP_DATE_LAST   = 4'd5;
  localparam logic [3:0] GRP_TIMER_FIRST = 4'd6;
  localparam logic [3:0] GRP_TIMER_LAST  = 4'd8;

  function automatic logic [3:0] group_first(input logic [1:0] sel);
    case (sel)
      2'd1:    return GRP_TIME_FIRST;
      2'd2:    return GRP_DATE_FIRST;
      2'd3:    return GRP_TIMER_FIRST;
      default: return GRP_ALL_FIRST;
    endcase
  endfunction

  function automatic logic [3:0] group_last(input logic [1:0] sel);
    case (sel)
      2'd1:    return GRP_TIME_LAST;
      2'd2:    return GRP_DATE_LAST;
      2'd3:    return GRP_TIMER_LAST;
      default: return GRP_ALL_LAST;
    endcase
  endfunction

  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      4'd8:    return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bank_writer_bus_cycle.sv
// One RTC write cycle: address strobe, recovery gap, data strobe, recovery gap,
// each phase timed by an 8-bit down-counter.
module rtc_bus_cycle #(
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_GAP   = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       go,
  input  logic       clr,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] ad,
  output logic       as_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       cycle_done
);
  import rtc_pkg::*;

  phase_e     phase;
  logic [7:0] cnt;
  logic [7:0] data_q;

  // Combinational so the caller can chain the next cycle without a dead clock.
  assign cycle_done = (phase == PH_DATA_GAP) && (cnt == '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      data_q <= '0;
      ad     <= '0;
      as_n   <= 1'b1;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
    end else if (go) begin
      phase  <= PH_ADDR_LOW;
      cnt    <= 8'(T_PULSE - 1);
      data_q <= data;
      ad     <= addr;
      as_n   <= 1'b0;
      cs_n   <= 1'b0;
      wr_n   <= 1'b0;
    end else if (clr) begin
      phase <= PH_IDLE;
      ad    <= '0;
      as_n  <= 1'b1;
    end else begin
      case (phase)
        PH_ADDR_LOW: begin
          if (cnt == '0) begin
            phase <= PH_ADDR_GAP;
            cnt   <= 8'(T_GAP - 1);
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_ADDR_GAP: begin
          if (cnt == '0) begin
            phase <= PH_DATA_LOW;
            cnt   <= 8'(T_PULSE - 1);
            ad    <= data_q;
            as_n  <= 1'b1;
            cs_n  <= 1'b0;
            wr_n  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_DATA_LOW: begin
          if (cnt == '0) begin
            phase <= PH_DATA_GAP;
            cnt   <= 8'(T_GAP - 1);
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_DATA_GAP: begin
          if (cnt == '0) begin
            phase <= PH_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rtc_bank_writer.sv
// Copies a selected group of register-bank entries to the external RTC,
// one bus write per entry followed by a commit write.
module rtc_bank_writer #(
  parameter int unsigned T_PULSE     = 10,
  parameter int unsigned T_GAP       = 5,
  parameter logic [7:0]  COMMIT_ADDR = 8'hF2,
  parameter logic [7:0]  COMMIT_DATA = 8'h00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Sel,
  output logic [3:0] Bank_Addr,
  input  logic [7:0] Bank_Data,
  output logic [7:0] AD,
  output logic       AD_OE,
  output logic       AS_n,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       Busy,
  output logic       Done
);
  import rtc_pkg::*;

  wr_state_e  state;
  logic [3:0] ptr;
  logic [3:0] last_idx;
  logic       fetch_second;
  logic       commit_done;

  logic       go;
  logic       bus_clr;
  logic       cycle_done;
  logic [7:0] bus_addr;
  logic [7:0] bus_data;

  // The NEXT decision is folded into the last DATA_GAP clock: the commit write
  // is launched straight from that clock, entries go back through FETCH.
  always_comb begin
    go       = 1'b0;
    bus_clr  = 1'b0;
    bus_addr = COMMIT_ADDR;
    bus_data = COMMIT_DATA;
    if (state == S_FETCH) begin
      bus_addr = rtc_addr(ptr);
      bus_data = Bank_Data;
      go       = fetch_second;
    end else if (state == S_CYCLE) begin
      go = cycle_done && (ptr >= last_idx) && !commit_done;
    end else if (state == S_DONE) begin
      bus_clr = 1'b1;
    end
  end

  rtc_bus_cycle #(
    .T_PULSE (T_PULSE),
    .T_GAP   (T_GAP)
  ) u_bus (
    .Clock      (Clock),
    .Reset      (Reset),
    .go         (go),
    .clr        (bus_clr),
    .addr       (bus_addr),
    .data       (bus_data),
    .ad         (AD),
    .as_n       (AS_n),
    .cs_n       (CS_n),
    .wr_n       (WR_n),
    .cycle_done (cycle_done)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      last_idx     <= '0;
      fetch_second <= 1'b0;
      commit_done  <= 1'b0;
      Bank_Addr    <= BANK_IDLE_ADDR;
      AD_OE        <= 1'b0;
      RD_n         <= 1'b1;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      RD_n <= 1'b1;
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state        <= S_FETCH;
            ptr          <= group_first(Sel);
            last_idx     <= group_last(Sel);
            Bank_Addr    <= group_first(Sel);
            fetch_second <= 1'b0;
            commit_done  <= 1'b0;
            Busy         <= 1'b1;
            AD_OE        <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!fetch_second) begin
            fetch_second <= 1'b1;
          end else begin
            state     <= S_CYCLE;
            Bank_Addr <= BANK_IDLE_ADDR;
          end
        end
        S_CYCLE: begin
          if (cycle_done) begin
            if (ptr < last_idx) begin
              state        <= S_FETCH;
              ptr          <= ptr + 4'd1;
              Bank_Addr    <= ptr + 4'd1;
              fetch_second <= 1'b0;
            end else if (!commit_done) begin
              commit_done <= 1'b1;
            end else begin
              state <= S_DONE;
              Busy  <= 1'b0;
              AD_OE <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bank_writer.sv
// Bench for rtc_bank_writer: a default-timing unit and a 1/1-timing unit share
// one register-bank model; a bus monitor logs RTC writes and watches the protocol.
module tb_rtc_bank_writer;

  localparam int P0 = 10;
  localparam int G0 = 5;
  localparam int P1 = 1;
  localparam int G1 = 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start_v [2];
  logic [1:0] sel_v   [2];
  logic [3:0] ba_v    [2];
  logic [7:0] bd_v    [2];
  logic [7:0] ad_v    [2];
  logic       oe_v    [2];
  logic       as_v    [2];
  logic       cs_v    [2];
  logic       wr_v    [2];
  logic       rd_v    [2];
  logic       busy_v  [2];
  logic       done_v  [2];

  always #5 Clock = ~Clock;

  rtc_bank_writer dut0 (
    .Clock(Clock), .Reset(Reset), .Start(start_v[0]), .Sel(sel_v[0]),
    .Bank_Addr(ba_v[0]), .Bank_Data(bd_v[0]), .AD(ad_v[0]), .AD_OE(oe_v[0]),
    .AS_n(as_v[0]), .CS_n(cs_v[0]), .WR_n(wr_v[0]), .RD_n(rd_v[0]),
    .Busy(busy_v[0]), .Done(done_v[0])
  );

  rtc_bank_writer #(.T_PULSE(P1), .T_GAP(G1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(start_v[1]), .Sel(sel_v[1]),
    .Bank_Addr(ba_v[1]), .Bank_Data(bd_v[1]), .AD(ad_v[1]), .AD_OE(oe_v[1]),
    .AS_n(as_v[1]), .CS_n(cs_v[1]), .WR_n(wr_v[1]), .RD_n(rd_v[1]),
    .Busy(busy_v[1]), .Done(done_v[1])
  );

  logic [7:0] bank [16];

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++)
      bd_v[i] <= (ba_v[i] < 4'd9) ? bank[ba_v[i]] : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] log0 [$];
  logic [15:0] log1 [$];
  int          done_cnt [2];
  logic        prev_wr  [2];
  logic        prev_as  [2];
  logic [7:0]  prev_ad  [2];
  logic [7:0]  pend     [2];
  logic        prev_rst = 1'b1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; prev_wr[i] = 1'b1; prev_as[i] = 1'b1;
      prev_ad[i] = 8'h00; pend[i] = 8'h00;
    end
  end

  // Bus model: a write is recorded when WR_n rises; the AS_n level tells address from data.
  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_v[i]) chk($sformatf("u%0d_rd_n_high", i), 32'(rd_v[i]), 32'd1);
      if (!Reset && !prev_rst) begin
        if (prev_wr[i] == 1'b0) begin
          chk($sformatf("u%0d_ad_stable", i), 32'(ad_v[i]), 32'(prev_ad[i]));
          chk($sformatf("u%0d_as_stable", i), 32'(as_v[i]), 32'(prev_as[i]));
        end
        if (prev_wr[i] == 1'b0 && wr_v[i] == 1'b1) begin
          if (!as_v[i]) pend[i] = ad_v[i];
          else if (i == 0) log0.push_back({pend[i], ad_v[i]});
          else log1.push_back({pend[i], ad_v[i]});
        end
      end
      if (done_v[i] === 1'b1) done_cnt[i]++;
      prev_wr[i] = wr_v[i];
      prev_as[i] = as_v[i];
      prev_ad[i] = ad_v[i];
    end
    prev_rst = Reset;
  end

  function automatic int n_entries(input int sel);
    return (sel == 0) ? 9 : 3;
  endfunction

  function automatic int first_idx(input int sel);
    return (sel == 0) ? 0 : 3 * (sel - 1);
  endfunction

  function automatic int xfer_len(input int sel, input int p, input int g);
    return n_entries(sel) * (2 + 2 * (p + g)) + 2 * (p + g);
  endfunction

  function automatic logic [7:0] ref_addr(input int idx);
    return (idx < 6) ? 8'(8'h21 + idx) : 8'(8'h41 + (idx - 6));
  endfunction

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  task automatic check_idle(input int i, input string tag);
    chk(tag, 32'({ba_v[i], ad_v[i], oe_v[i], as_v[i], cs_v[i], wr_v[i], rd_v[i], busy_v[i], done_v[i]}),
        32'({4'h9, 8'h00, 7'b0111100}));
  endtask

  task automatic check_log(input int i, input int sel, input string tag);
    int n, f, sz;
    logic [15:0] got, exp;
    n  = n_entries(sel);
    f  = first_idx(sel);
    sz = (i == 0) ? log0.size() : log1.size();
    chk($sformatf("%s_nwrites", tag), 32'(sz), 32'(n + 1));
    for (int k = 0; k <= n; k++) begin
      exp = (k < n) ? {ref_addr(f + k), bank[f + k]} : 16'hF200;
      got = 16'hxxxx;
      if (k < sz) got = (i == 0) ? log0[k] : log1[k];
      chk($sformatf("%s_write%0d", tag, k), 32'(got), 32'(exp));
    end
  endtask

  task automatic run_xfer(input int i, input int sel, input int p, input int g, input string tag);
    int n;
    clear_logs();
    @(posedge Clock); #1;
    start_v[i] = 1'b1;
    sel_v[i]   = 2'(sel);
    @(posedge Clock); #1;
    start_v[i] = 1'b0;
    sel_v[i]   = 2'(3 - sel);
    n = 1;
    chk($sformatf("%s_busy_rise", tag), 32'(busy_v[i]), 32'd1);
    while (done_v[i] !== 1'b1 && n < 2000) begin
      @(posedge Clock); #1;
      n++;
    end
    chk($sformatf("%s_done_at", tag), 32'(n), 32'(xfer_len(sel, p, g) + 1));
    @(posedge Clock); #1;
    chk($sformatf("%s_done_width", tag), 32'(done_v[i]), 32'd0);
    chk($sformatf("%s_busy_fall", tag), 32'(busy_v[i]), 32'd0);
    chk($sformatf("%s_done_count", tag), 32'(done_cnt[i]), 32'd1);
    check_log(i, sel, tag);
    check_idle(i, $sformatf("%s_idle_after", tag));
  endtask

  initial begin
    int n, sel;
    for (int k = 0; k < 16; k++) bank[k] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      sel_v[i]   = 2'd0;
    end

    // Reset held with Start asserted: reset must win.
    start_v[0] = 1'b1; sel_v[0] = 2'd1;
    start_v[1] = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check_idle(0, "rst_u0");
    check_idle(1, "rst_u1");
    Reset = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clock); #1;
      if (c % 5 == 4) begin
        check_idle(0, $sformatf("idle_u0_c%0d", c));
        check_idle(1, $sformatf("idle_u1_c%0d", c));
      end
    end

    // Time group with fixed BCD contents.
    bank[0] = 8'h45; bank[1] = 8'h30; bank[2] = 8'h12;
    run_xfer(0, 1, P0, G0, "sel1");

    // Full bank 01..09 on both timings.
    for (int k = 0; k < 9; k++) bank[k] = 8'(k + 1);
    run_xfer(0, 0, P0, G0, "sel0");
    run_xfer(1, 0, P1, G1, "sel0_fast");

    // Extra Start pulses during a date transfer must be dropped.
    for (int k = 0; k < 9; k++) bank[k] = 8'($urandom_range(0, 255));
    clear_logs();
    @(posedge Clock); #1;
    start_v[0] = 1'b1; sel_v[0] = 2'd2;
    @(posedge Clock); #1;
    start_v[0] = 1'b0;
    n = 1;
    while (done_v[0] !== 1'b1 && n < 2000) begin
      start_v[0] = (n == 5 || n == 60);
      @(posedge Clock); #1;
      n++;
    end
    start_v[0] = 1'b0;
    chk("ignore_done_at", 32'(n), 32'(xfer_len(2, P0, G0) + 1));
    repeat (200) @(posedge Clock);
    #1;
    chk("ignore_done_count", 32'(done_cnt[0]), 32'd1);
    chk("ignore_busy_after", 32'(busy_v[0]), 32'd0);
    check_log(0, 2, "ignore");

    // Reset in the DATA_LOW of entry 1 of a full transfer.
    for (int k = 0; k < 9; k++) bank[k] = 8'($urandom_range(0, 255));
    clear_logs();
    @(posedge Clock); #1;
    start_v[0] = 1'b1; sel_v[0] = 2'd0;
    @(posedge Clock); #1;
    start_v[0] = 1'b0;
    n = 1;
    while (n < (2 + 2 * (P0 + G0)) + 2 + P0 + G0 + 3) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("midrst_in_data_low", 32'({wr_v[0], as_v[0], ad_v[0]}), 32'({1'b0, 1'b1, bank[1]}));
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("midrst_strobes", 32'({cs_v[0], wr_v[0], busy_v[0]}), 32'({1'b1, 1'b1, 1'b0}));
    check_idle(0, "midrst_idle");
    @(posedge Clock); #1;
    for (int k = 0; k < 9; k++) bank[k] = 8'($urandom_range(0, 255));
    run_xfer(0, 3, P0, G0, "after_rst_sel3");

    // Random groups and contents on the fast unit.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 9; k++) bank[k] = 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 3));
      run_xfer(1, sel, P1, G1, $sformatf("rand%0d_sel%0d", r, sel));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
